// File: rtl/multiplexed_display_scanner_if.sv
// Bus between a digit-value source and the multiplexed display scanner.
// The master drives values and scan controls; the slave returns decoder and digit-select outputs.
interface multiplexed_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    lz_suppress;
    logic [3:0]              bcd_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    frame_start;

    modport master (
        output en, bcd_in, dp_in, lz_suppress,
        input  bcd_out, dp_out, digit_sel, frame_start
    );

    modport slave (
        input  en, bcd_in, dp_in, lz_suppress,
        output bcd_out, dp_out, digit_sel, frame_start
    );
endinterface

// File: rtl/multiplexed_display_scanner.sv
// Time-multiplexes one BCD-to-7-segment decoder across NUM_DIGITS common-anode digits,
// with a blanking gap before each digit and a per-frame snapshot of the digit values.
module multiplexed_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input logic                          clk,
    input logic                          rst_n,
    multiplexed_display_scanner_if.slave bus
);
    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t                         state, state_nxt;
    logic [IDX_W-1:0]               idx, idx_nxt;
    logic [CNT_W-1:0]               cnt, cnt_nxt;
    logic                           active, active_nxt;
    logic                           frame_nxt;

    logic [NUM_DIGITS-1:0][3:0]     snap_bcd;
    logic [NUM_DIGITS-1:0]          snap_dp;
    logic [NUM_DIGITS-1:0]          supp;

    logic [3:0]                     bcd_nxt, bcd_p0;
    logic                           dp_nxt, dp_p0;
    logic [NUM_DIGITS-1:0]          sel_nxt, sel_p0;
    logic                           frame_p0;

    // A digit is suppressed while it and every higher digit are zero; digit 0 never is.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(
        input logic [NUM_DIGITS-1:0][3:0] digits,
        input logic                       on
    );
        logic [NUM_DIGITS-1:0] m;
        logic                  run;
        m   = '0;
        run = on;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run  = run && (digits[i] == 4'h0);
            m[i] = run;
        end
        return m;
    endfunction

    assign supp = lz_mask(snap_bcd, bus.lz_suppress);

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        active_nxt = active;
        frame_nxt  = 1'b0;
        if (!bus.en) begin
            state_nxt  = BLANK;
            idx_nxt    = '0;
            cnt_nxt    = '0;
            active_nxt = 1'b0;
        end else if (!active) begin
            // Idle after reset or disable: the next cycle is the first blank of a fresh frame.
            state_nxt  = BLANK;
            idx_nxt    = '0;
            cnt_nxt    = '0;
            active_nxt = 1'b1;
            frame_nxt  = 1'b1;
        end else if (state == BLANK) begin
            if (cnt == BLANK_LAST) begin
                state_nxt = DRIVE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else begin
            if (cnt == DWELL_LAST) begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
                if (idx == IDX_LAST) begin
                    idx_nxt   = '0;
                    frame_nxt = 1'b1;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // Outputs are registered from the next state; DRIVE is never entered on a snapshot edge.
    always_comb begin
        sel_nxt = '1;
        bcd_nxt = 4'hF;
        dp_nxt  = 1'b1;
        if (active_nxt && state_nxt == DRIVE) begin
            sel_nxt = ~(NUM_DIGITS'(1) << idx_nxt);
            bcd_nxt = supp[idx_nxt] ? 4'hF : snap_bcd[idx_nxt];
            dp_nxt  = ~snap_dp[idx_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BLANK;
            idx      <= '0;
            cnt      <= '0;
            active   <= 1'b0;
            snap_bcd <= '1;
            snap_dp  <= '0;
            bcd_p0   <= 4'hF;
            dp_p0    <= 1'b1;
            sel_p0   <= '1;
            frame_p0 <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            cnt      <= cnt_nxt;
            active   <= active_nxt;
            bcd_p0   <= bcd_nxt;
            dp_p0    <= dp_nxt;
            sel_p0   <= sel_nxt;
            frame_p0 <= frame_nxt;
            if (frame_nxt) begin
                snap_bcd <= bus.bcd_in;
                snap_dp  <= bus.dp_in;
            end
        end
    end

    assign bus.bcd_out     = bcd_p0;
    assign bus.dp_out      = dp_p0;
    assign bus.digit_sel   = sel_p0;
    assign bus.frame_start = frame_p0;

endmodule

// File: tb/tb_multiplexed_display_scanner.sv
// Randomized self-checking bench for multiplexed_display_scanner against a frame-arithmetic model.
module tb_multiplexed_display_scanner;
    localparam int N  = 4;
    localparam int DW = 4;
    localparam int BL = 2;
    localparam int SLOT = BL + DW;
    localparam int FP = N * SLOT;
    localparam logic [9:0] RST_VEC = 10'b1111_1111_10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multiplexed_display_scanner_if #(.NUM_DIGITS(N)) bus ();

    multiplexed_display_scanner #(
        .NUM_DIGITS  (N),
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: cycles since frame start; snapshot taken every FP cycles.
    logic        m_run;
    int          m_t;
    logic [15:0] m_snap;
    logic [3:0]  m_dp;
    logic        m_lz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0;
            m_t   = 0;
            m_lz  = 1'b0;
        end else begin
            m_lz = bus.lz_suppress;
            if (!bus.en) begin
                m_run = 1'b0;
            end else if (!m_run) begin
                m_run  = 1'b1;
                m_t    = 0;
                m_snap = bus.bcd_in;
                m_dp   = bus.dp_in;
            end else begin
                m_t = m_t + 1;
                if (m_t % FP == 0) begin
                    m_snap = bus.bcd_in;
                    m_dp   = bus.dp_in;
                end
            end
        end
    end

    function automatic logic [9:0] expv();
        int ph, d, w;
        logic [15:0] sh;
        logic [3:0]  code;
        if (!m_run) return RST_VEC;
        ph = m_t % FP;
        d  = ph / SLOT;
        w  = ph % SLOT;
        if (w < BL) return {4'hF, 4'hF, 1'b1, (ph == 0)};
        sh   = m_snap >> (4 * d);
        code = (m_lz && d > 0 && sh == 16'h0) ? 4'hF : sh[3:0];
        return {~(4'b0001 << d), code, ~m_dp[d], 1'b0};
    endfunction

    function automatic logic [9:0] obs();
        return {bus.digit_sel, bus.bcd_out, bus.dp_out, bus.frame_start};
    endfunction

    task automatic wait_sel(input logic [3:0] sel, input string tag);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.digit_sel === sel) break;
        end
        checks++;
        if (k == 200) begin
            errors++;
            $display("FAIL %s timeout waiting for digit_sel=%b", tag, sel);
        end
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.bcd_in = 16'h0; bus.dp_in = 4'h0; bus.lz_suppress = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== RST_VEC) begin
            errors++;
            $display("FAIL reset_state got %b want %b", obs(), RST_VEC);
        end
    endtask

    task automatic test_basic_scan();
        int last;
        last = -1;
        bus.en = 1'b1; bus.bcd_in = 16'h4321;
        rst_n = 1'b1;
        for (int i = 0; i < 3 * FP; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL basic_scan cyc %0d got %b want %b", i, obs(), expv());
            end
            if (bus.frame_start === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (i - last !== FP) begin
                        errors++;
                        $display("FAIL frame_period got %0d want %0d", i - last, FP);
                    end
                end
                last = i;
            end
        end
    endtask

    task automatic test_tearing();
        wait_sel(4'b1101, "tear_wait");
        bus.bcd_in = 16'h8765;
        wait_sel(4'b1011, "tear_wait2");
        checks++;
        if (bus.bcd_out !== 4'h3) begin
            errors++;
            $display("FAIL tearing_digit2 got %h want 3", bus.bcd_out);
        end
        for (int i = 0; i < 2 * FP; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL tearing cyc %0d got %b want %b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_leading_zeros();
        bus.lz_suppress = 1'b1;
        bus.bcd_in = 16'h0040;
        for (int i = 0; i < 2 * FP; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL lz_0040 cyc %0d got %b want %b", i, obs(), expv());
            end
        end
        wait_sel(4'b0111, "lz_wait");
        checks++;
        if (bus.bcd_out !== 4'hF) begin
            errors++;
            $display("FAIL lz_digit3 got %h want f", bus.bcd_out);
        end
        bus.bcd_in = 16'h0000;
        for (int i = 0; i < 2 * FP; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL lz_0000 cyc %0d got %b want %b", i, obs(), expv());
            end
        end
        wait_sel(4'b1110, "lz_wait0");
        checks++;
        if (bus.bcd_out !== 4'h0) begin
            errors++;
            $display("FAIL lz_digit0 got %h want 0", bus.bcd_out);
        end
        bus.lz_suppress = 1'b0;
    endtask

    task automatic test_dp_invalid();
        bus.dp_in = 4'b0100;
        bus.bcd_in = 16'hB321;
        for (int i = 0; i < 2 * FP; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL dp_invalid cyc %0d got %b want %b", i, obs(), expv());
            end
        end
        wait_sel(4'b0111, "dp_wait");
        checks++;
        if (bus.bcd_out !== 4'hB || bus.dp_out !== 1'b1) begin
            errors++;
            $display("FAIL dp_digit3 got %h/%b want b/1", bus.bcd_out, bus.dp_out);
        end
    endtask

    task automatic test_enable();
        bus.bcd_in = 16'h9876;
        wait_sel(4'b1011, "en_wait");
        bus.en = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== RST_VEC) begin
            errors++;
            $display("FAIL en_low got %b want %b", obs(), RST_VEC);
        end
        bus.bcd_in = 16'h5A05;
        bus.en = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.frame_start !== 1'b1 || bus.digit_sel !== 4'hF) begin
            errors++;
            $display("FAIL en_rise got fs=%b sel=%b want 1/1111", bus.frame_start, bus.digit_sel);
        end
        for (int i = 0; i < FP + 6; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL enable cyc %0d got %b want %b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random cyc %0d got %b want %b", i, obs(), expv());
            end
            if ($urandom_range(0, 9) == 0) bus.bcd_in = 16'($urandom);
            if ($urandom_range(0, 15) == 0) bus.bcd_in = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) bus.dp_in = 4'($urandom);
            if ($urandom_range(0, 29) == 0) bus.lz_suppress = ~bus.lz_suppress;
            if ($urandom_range(0, 49) == 0) bus.en = ~bus.en;
            if (!bus.en && $urandom_range(0, 3) == 0) bus.en = 1'b1;
        end
        bus.en = 1'b1;
    endtask

    task automatic test_async_reset();
        wait_sel(4'b1101, "arst_wait");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== RST_VEC) begin
            errors++;
            $display("FAIL async_reset got %b want %b", obs(), RST_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FP + 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL post_reset cyc %0d got %b want %b", i, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_tearing();
        test_leading_zeros();
        test_dp_invalid();
        test_enable();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
